// File: rtl/aes_round_control_if.sv
// aes_round_control_if
//
// Purpose: bundles the start/abort controls and the round-sequencing status of
// aes_round_control into one interface.
//
// Parameters:
//   COLL_W : width of coll_cnt; must match the COLL_W of the attached controller.
//
// Signals (directions seen from the controller, i.e. the slave modport):
//   in_en                     in   start pulse, block loaded into datapath same cycle
//   key_len[1:0]              in   00 AES-128, 01 AES-192, 10 AES-256, 11 illegal
//   abort                     in   synchronous cancel
//   key_ready                 out  round-key request strobe
//   en_mixcol                 out  high during the final round (MixColumns bypass)
//   round_idx[3:0]            out  current round 1..Nr, 0 when not busy
//   idle                      out  busy flag (historical name), high accept..out_en
//   out_en                    out  one-cycle result valid
//   in_en_collision_irq_pulse out  one-cycle pulse per start rejected while busy
//   cfg_err_pulse             out  one-cycle pulse per start with key_len = 11
//   coll_cnt[COLL_W-1:0]      out  saturating collision count
interface aes_round_control_if #(
    parameter int unsigned COLL_W = 8
);
    logic              in_en;
    logic [1:0]        key_len;
    logic              abort;
    logic              key_ready;
    logic              en_mixcol;
    logic [3:0]        round_idx;
    logic              idle;
    logic              out_en;
    logic              in_en_collision_irq_pulse;
    logic              cfg_err_pulse;
    logic [COLL_W-1:0] coll_cnt;

    // Requester side: issues starts/aborts, observes sequencing status.
    modport master (
        output in_en,
        output key_len,
        output abort,
        input  key_ready,
        input  en_mixcol,
        input  round_idx,
        input  idle,
        input  out_en,
        input  in_en_collision_irq_pulse,
        input  cfg_err_pulse,
        input  coll_cnt
    );

    // Controller side.
    modport slave (
        input  in_en,
        input  key_len,
        input  abort,
        output key_ready,
        output en_mixcol,
        output round_idx,
        output idle,
        output out_en,
        output in_en_collision_irq_pulse,
        output cfg_err_pulse,
        output coll_cnt
    );
endinterface

// File: rtl/aes_round_control.sv
// aes_round_control
//
// Purpose: round sequencer for the AES datapath. Accepts a block start, picks
// Nr = 10/12/14 from the key length, spends CYCLES_PER_ROUND clocks per round,
// strobes round-key requests, flags the final round (no MixColumns) and emits a
// one-cycle out_en. Starts while busy are rejected and counted; a synchronous
// abort returns to idle without producing a result.
//
// Parameters:
//   CYCLES_PER_ROUND : clocks per round, 1..15
//   PH_W             : phase counter width, 2**PH_W >= CYCLES_PER_ROUND, >= 1
//   COLL_W           : width of the saturating collision counter
//
// Ports:
//   clk    : rising-edge clock
//   kill_n : asynchronous active-low reset
//   bus    : aes_round_control_if.slave (controls in, status out)
module aes_round_control #(
    parameter int unsigned CYCLES_PER_ROUND = 3,
    parameter int unsigned PH_W             = 2,
    parameter int unsigned COLL_W           = 8
) (
    input logic                clk,
    input logic                kill_n,
    aes_round_control_if.slave bus
);

    localparam logic [PH_W-1:0]   PhLast  = PH_W'(CYCLES_PER_ROUND - 1);
    localparam logic [COLL_W-1:0] CollMax = '1;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e            state_q;
    logic [3:0]        nr_q;
    logic [3:0]        round_q;
    logic [PH_W-1:0]   phase_q;
    logic              out_en_q;
    logic              coll_pulse_q;
    logic              cfg_err_q;
    logic [COLL_W-1:0] coll_cnt_q;

    logic busy;
    logic key_legal;
    logic accept;
    logic collision;
    logic cfg_err;
    logic round_end;
    logic last_round;

    function automatic logic [3:0] rounds_for(input logic [1:0] key_len);
        case (key_len)
            2'b00:   rounds_for = 4'd10;
            2'b01:   rounds_for = 4'd12;
            default: rounds_for = 4'd14;  // 11 is never accepted
        endcase
    endfunction

    // Abort outranks every start: a start in an abort cycle is neither accepted,
    // counted as a collision, nor flagged as a configuration error.
    always_comb begin
        busy       = (state_q == StBusy);
        key_legal  = (bus.key_len != 2'b11);
        accept     = bus.in_en & ~busy & ~bus.abort & key_legal;
        collision  = bus.in_en & busy & ~bus.abort;
        cfg_err    = bus.in_en & ~busy & ~bus.abort & ~key_legal;
        round_end  = busy & (phase_q == PhLast);
        last_round = (round_q == nr_q);
    end

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state_q      <= StIdle;
            nr_q         <= 4'd0;
            round_q      <= 4'd0;
            phase_q      <= '0;
            out_en_q     <= 1'b0;
            coll_pulse_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            coll_cnt_q   <= '0;
        end else begin
            out_en_q     <= 1'b0;
            coll_pulse_q <= collision;
            cfg_err_q    <= cfg_err;
            if (collision && (coll_cnt_q != CollMax)) begin
                coll_cnt_q <= coll_cnt_q + COLL_W'(1);
            end

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StBusy;
                        nr_q    <= rounds_for(bus.key_len);
                        round_q <= 4'd1;
                        phase_q <= '0;
                    end
                end
                StBusy: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                        round_q <= 4'd0;
                        phase_q <= '0;
                    end else if (round_end && last_round) begin
                        state_q  <= StIdle;
                        round_q  <= 4'd0;
                        phase_q  <= '0;
                        out_en_q <= 1'b1;
                    end else if (round_end) begin
                        round_q <= round_q + 4'd1;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // key_ready: key 0 on the accept cycle, key r on the first cycle of round r.
    assign bus.key_ready                 = accept | (busy & (phase_q == '0));
    assign bus.en_mixcol                 = busy & last_round;
    assign bus.round_idx                 = round_q;
    assign bus.idle                      = busy;
    assign bus.out_en                    = out_en_q;
    assign bus.in_en_collision_irq_pulse = coll_pulse_q;
    assign bus.cfg_err_pulse             = cfg_err_q;
    assign bus.coll_cnt                  = coll_cnt_q;

    a_out_en_single : assert property (@(posedge clk) disable iff (!kill_n)
        bus.out_en |=> !bus.out_en);

    a_no_key_on_cfg_err : assert property (@(posedge clk) disable iff (!kill_n)
        cfg_err |-> !bus.key_ready);

    a_round_in_range : assert property (@(posedge clk) disable iff (!kill_n)
        busy |-> (round_q >= 4'd1) && (round_q <= nr_q));

endmodule
